// File: rtl/acs_array.sv
// -----------------------------------------------------------------------------
// acs_array
// Full-trellis, registered add-compare-select unit for a rate-1/2 Viterbi
// decoder. Each accepted beat advances all NS = 2^(K-1) path metrics by one
// trellis step, producing one decision bit per next-state and the index of the
// best (minimum) path metric.
//
// Optional feature macro: ACS_NORM_EN
//   defined   : unsigned compare, MSB-clear normalisation when every metric has
//               its MSB set (o_norm pulses on that beat)
//   undefined : modulo-2^PM_W metrics, compare via MSB of the difference,
//               o_norm held at 0
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin new frame (re-initialise metrics, enter RUN)
//   i_valid      i_BM carries a valid symbol
//   i_BM         four branch metrics, slice {c0,c1} at [idx*BM_W +: BM_W]
//   o_valid      outputs updated this cycle (single-cycle pulse)
//   o_dec        decision bits, bit s for next-state s (1 = path 1 chosen)
//   o_PM         path metrics, state s at [s*PM_W +: PM_W]
//   o_best_state index of the minimum path metric (lowest index on ties)
//   o_norm       normalisation applied on this step (single-cycle pulse)
//   o_step_cnt   accepted steps since last start, saturating
// -----------------------------------------------------------------------------
module acs_array #(
    parameter int             K    = 3,
    parameter logic [K-1:0]   G0   = 3'b111,
    parameter logic [K-1:0]   G1   = 3'b101,
    parameter int             BM_W = 2,
    parameter int             PM_W = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_valid,
    input  logic [4*BM_W-1:0]         i_BM,
    output logic                      o_valid,
    output logic [(1<<(K-1))-1:0]     o_dec,
    output logic [(1<<(K-1))*PM_W-1:0] o_PM,
    output logic [K-2:0]              o_best_state,
    output logic                      o_norm,
    output logic [15:0]               o_step_cnt
);

    localparam int NS = 1 << (K - 1);

    typedef logic [NS-1:0][PM_W-1:0] pm_vec_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Start-of-frame metrics: state 0 favoured, all others a quarter-range away.
    function automatic pm_vec_t init_metrics();
        pm_vec_t v;
        for (int s = 0; s < NS; s++) begin
            v[s] = (s == 0) ? {PM_W{1'b0}} : {2'b01, {(PM_W-2){1'b0}}};
        end
        return v;
    endfunction

    // Metric ordering; in the wrapping build the sign of the modular
    // difference decides, which is valid while the metric spread stays
    // below half the range.
    function automatic logic cmp_less(input logic [PM_W-1:0] a,
                                      input logic [PM_W-1:0] b);
`ifdef ACS_NORM_EN
        return (a < b);
`else
        logic [PM_W-1:0] d;
        d = a - b;
        return d[PM_W-1];
`endif
    endfunction

    // Encoder output bit for a K-bit register image and generator.
    function automatic logic code_bit(input logic [K-1:0] r,
                                      input logic [K-1:0] g);
        return ^(r & g);
    endfunction

    state_t          state_q, state_d;
    pm_vec_t         pm_q, pm_d, pm_prev_s, pm_acs_s, pm_new_s;
    logic [NS-1:0]   dec_q, dec_d, dec_s;
    logic [K-2:0]    best_q, best_d, best_s;
    logic            norm_q, norm_d, norm_s;
    logic            valid_q, valid_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            accept_s;

    // Add-compare-select over the whole trellis, then normalise and find best.
    always_comb begin
        pm_prev_s = i_start ? init_metrics() : pm_q;
        pm_acs_s  = '0;
        dec_s     = '0;
        for (int ns = 0; ns < NS; ns++) begin
            logic [K-2:0]    p0, p1;
            logic            u;
            logic [K-1:0]    r0, r1;
            logic [1:0]      idx0, idx1;
            logic [PM_W-1:0] m0, m1;
            logic            sel;
            u    = ns[0];
            p0   = (K-1)'(ns >> 1);
            p1   = p0 | (K-1)'(NS >> 1);
            r0   = {p0, u};
            r1   = {p1, u};
            idx0 = {code_bit(r0, G0), code_bit(r0, G1)};
            idx1 = {code_bit(r1, G0), code_bit(r1, G1)};
            m0   = pm_prev_s[p0] + PM_W'(i_BM[int'(idx0)*BM_W +: BM_W]);
            m1   = pm_prev_s[p1] + PM_W'(i_BM[int'(idx1)*BM_W +: BM_W]);
            // Ties resolve to path 1.
            sel  = ~cmp_less(m0, m1);
            dec_s[ns]    = sel;
            pm_acs_s[ns] = sel ? m1 : m0;
        end

        pm_new_s = pm_acs_s;
`ifdef ACS_NORM_EN
        norm_s = 1'b1;
        for (int s = 0; s < NS; s++) begin
            norm_s = norm_s & pm_acs_s[s][PM_W-1];
        end
        if (norm_s) begin
            for (int s = 0; s < NS; s++) begin
                pm_new_s[s][PM_W-1] = 1'b0;
            end
        end else begin
            pm_new_s = pm_acs_s;
        end
`else
        norm_s = 1'b0;
`endif

        best_s = '0;
        for (int s = 1; s < NS; s++) begin
            if (cmp_less(pm_new_s[s], pm_new_s[best_s])) begin
                best_s = (K-1)'(s);
            end else begin
                best_s = best_s;
            end
        end
    end

    // Frame FSM and next-state selection for all registered outputs.
    always_comb begin
        state_d  = state_q;
        pm_d     = pm_q;
        dec_d    = dec_q;
        best_d   = best_q;
        norm_d   = 1'b0;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;
        accept_s = i_valid & (i_start | (state_q == ST_RUN));

        case (state_q)
            ST_IDLE: state_d = i_start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (accept_s) begin
            pm_d    = pm_new_s;
            dec_d   = dec_s;
            best_d  = best_s;
            norm_d  = norm_s;
            valid_d = 1'b1;
            if (i_start) begin
                cnt_d = 16'd1;
            end else if (cnt_q == 16'hFFFF) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (i_start) begin
            pm_d  = init_metrics();
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pm_q    <= init_metrics();
            dec_q   <= '0;
            best_q  <= '0;
            norm_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pm_q    <= pm_d;
            dec_q   <= dec_d;
            best_q  <= best_d;
            norm_q  <= norm_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_dec        = dec_q;
    assign o_PM         = pm_q;
    assign o_best_state = best_q;
    assign o_norm       = norm_q;
    assign o_step_cnt   = cnt_q;

endmodule
